// File: rtl/simon_pkt_serialiser.sv
// Packet-to-byte serialiser: captures one output packet from the SIMON output stage
// and streams it MSB byte first over a valid/ready byte link, optionally followed by an XOR checksum.
module simon_pkt_serialiser #(
    parameter int N        = 24,
    parameter bit CHECKSUM = 1'b1,
    localparam int PKT_BYTES = N / 2 + 2,
    localparam int IDX_W     = $clog2(PKT_BYTES)
) (
    input  logic                   clk,
    input  logic                   nR,
    input  logic                   out_donePKT,
    input  logic [8*PKT_BYTES-1:0] out,
    output logic                   out_readPKT,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_CSUM = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [8*PKT_BYTES-1:0] pkt_reg, pkt_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic                   read_reg, read_next;
    logic                   valid_reg, valid_next;
    logic                   busy_reg, busy_next;

    logic [7:0] byte_w [PKT_BYTES];
    logic [7:0] csum_w;
    logic       xfer_w;

    genvar gi;
    generate
        for (gi = 0; gi < PKT_BYTES; gi++) begin : g_bytes
            assign byte_w[gi] = pkt_reg[8*gi +: 8];
        end
    endgenerate

    // Purely a function of the captured buffer, so it cannot drift while the frame is in flight.
    always_comb begin
        csum_w = '0;
        for (int i = 0; i < PKT_BYTES; i++) begin
            csum_w = csum_w ^ byte_w[i];
        end
    end

    assign xfer_w = valid_reg && tx_ready;

    always_comb begin
        state_next = state_reg;
        pkt_next   = pkt_reg;
        idx_next   = idx_reg;
        read_next  = 1'b0;
        valid_next = valid_reg;
        busy_next  = busy_reg;
        tx_data    = 8'h00;
        tx_last    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (out_donePKT) begin
                    pkt_next   = out;
                    idx_next   = IDX_W'(PKT_BYTES - 1);
                    read_next  = 1'b1;
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                tx_data = byte_w[idx_reg];
                tx_last = !CHECKSUM && (idx_reg == '0);
                if (xfer_w) begin
                    if (idx_reg != '0) begin
                        idx_next = idx_reg - 1'b1;
                    end else if (CHECKSUM) begin
                        state_next = S_CSUM;
                    end else begin
                        state_next = S_IDLE;
                        valid_next = 1'b0;
                        busy_next  = 1'b0;
                    end
                end
            end
            S_CSUM: begin
                tx_data = csum_w;
                tx_last = 1'b1;
                if (xfer_w) begin
                    state_next = S_IDLE;
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_reg <= S_IDLE;
            pkt_reg   <= '0;
            idx_reg   <= '0;
            read_reg  <= 1'b0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pkt_reg   <= pkt_next;
            idx_reg   <= idx_next;
            read_reg  <= read_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
        end
    end

    assign out_readPKT = read_reg;
    assign tx_valid    = valid_reg;
    assign busy        = busy_reg;

endmodule
